// File: rtl/mprj_io_cfg_pkg.sv
// Shared types and constants for the pad-configuration serial loader.
// Bit offsets describe the layout of one pad's configuration word.
package mprj_io_cfg_pkg;

  localparam int CFG_BITS_DEFAULT = 13;

  localparam int CFG_MGMT_EN     = 0;
  localparam int CFG_OUT_DIS     = 1;
  localparam int CFG_HOLD_OVR    = 2;
  localparam int CFG_INP_DIS     = 3;
  localparam int CFG_IB_MODE_SEL = 4;
  localparam int CFG_AN_EN       = 5;
  localparam int CFG_AN_SEL      = 6;
  localparam int CFG_AN_POL      = 7;
  localparam int CFG_SLOW        = 8;
  localparam int CFG_VTRIP_SEL   = 9;
  localparam int CFG_DM_LSB      = 10;
  localparam int CFG_DM_WIDTH    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHAIN_RST,
    ST_FETCH,
    ST_CAPTURE,
    ST_SETUP,
    ST_HIGH,
    ST_LOAD,
    ST_DONE
  } seq_state_e;

  // States whose length is set by the divided phase counter.
  function automatic logic is_timed_state(input seq_state_e s);
    return (s == ST_CHAIN_RST) || (s == ST_SETUP) || (s == ST_HIGH) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/mprj_io_cfg_tick.sv
// Phase counter: phase_end marks the last of CLK_DIV cycles in a timed phase.
// Held at zero while clear is high so every phase starts from a fresh count.
module mprj_io_cfg_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign phase_end = (div_cnt == LAST);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear || phase_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mprj_io_cfg_sequencer.sv
// Fetches one config word per pad and shifts it MSB-first into the pad chain,
// farthest pad first, then strobes serial_load so all pads update together.
module mprj_io_cfg_sequencer
  import mprj_io_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = CFG_BITS_DEFAULT,
  parameter int CLK_DIV  = 1,
  parameter int AW       = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic                xfer_start,
  input  logic                xfer_abort,
  input  logic                chain_reset_en,
  output logic                cfg_rd,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_rdata,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                serial_resetn,
  output logic                busy,
  output logic                done
);

  localparam int PW = $clog2(NUM_PADS);
  localparam int BW = $clog2(CFG_BITS);

  seq_state_e          state_q, state_d;
  logic [PW-1:0]       pad_q, pad_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CFG_BITS-1:0] shreg_q, shreg_d;
  logic                phase_end;

  mprj_io_cfg_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (wb_clk_i),
    .rst_n    (wb_rstn_i),
    .clear    (!is_timed_state(state_q)),
    .phase_end(phase_end)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_start) begin
          pad_d   = PW'(NUM_PADS - 1);
          state_d = chain_reset_en ? ST_CHAIN_RST : ST_FETCH;
        end
      end
      ST_CHAIN_RST: if (phase_end) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        shreg_d = cfg_rdata;
        bit_d   = BW'(CFG_BITS - 1);
        state_d = ST_SETUP;
      end
      ST_SETUP:     if (phase_end) state_d = ST_HIGH;
      ST_HIGH: begin
        if (phase_end) begin
          if (bit_q != '0) begin
            bit_d   = bit_q - BW'(1);
            state_d = ST_SETUP;
          end else if (pad_q != '0) begin
            pad_d   = pad_q - PW'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD:      if (phase_end) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (xfer_abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q       <= ST_IDLE;
      pad_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      cfg_rd        <= 1'b0;
      cfg_addr      <= '0;
      serial_clock  <= 1'b0;
      serial_data   <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pad_q         <= pad_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      cfg_rd        <= (state_d == ST_FETCH);
      if (state_d == ST_FETCH) cfg_addr <= AW'(pad_d);
      serial_clock  <= (state_d == ST_HIGH);
      if (state_d == ST_SETUP) serial_data <= shreg_d[bit_d];
      serial_load   <= (state_d == ST_LOAD);
      serial_resetn <= (state_d != ST_CHAIN_RST);
      busy          <= (state_d != ST_IDLE);
      done          <= (state_d == ST_DONE);
    end
  end

endmodule
